// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//
// Turns a clean, debounced, clk-synchronous button level into single-cycle
// event pulses (press, release, short click, double click, long press) and
// keeps a wrapping count of presses.
//
// Parameters:
//   ACTIVE_LEVEL - btn_in level that means "pressed" (1 = active-high)
//   LONG_TIME    - consecutive pressed samples that make a long press (>= 2)
//   DBL_GAP      - released samples after a click within which a second press
//                  still forms a double click (>= 2)
//   CNT_W        - timer width, 2**CNT_W > max(LONG_TIME, DBL_GAP)
//
// Ports:
//   clk           - system clock
//   rst_n         - asynchronous active-low reset
//   btn_in        - debounced button level, synchronous to clk
//   held          - registered pressed level (p delayed one cycle)
//   press_pulse   - one-cycle pulse per press
//   release_pulse - one-cycle pulse per release
//   short_click   - one-cycle pulse: single click, no second press in time
//   double_click  - one-cycle pulse: second click of a pair released
//   long_press    - one-cycle pulse: button held LONG_TIME samples
//   press_count   - presses since reset, wraps 255 -> 0
// -----------------------------------------------------------------------------
module button_event #(
  parameter logic ACTIVE_LEVEL = 1'b1,
  parameter int   LONG_TIME    = 6000000,
  parameter int   DBL_GAP      = 3000000,
  parameter int   CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_click,
  output logic       double_click,
  output logic       long_press,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  // Terminal timer values: the timer is 1 on the first sample of a phase, so
  // hitting N-1 while still in the phase means N samples have been seen.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);
  localparam logic [CNT_W-1:0] TMR_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TMR_ZERO  = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_s;
  logic             p_q_r;
  logic             pressed_s;
  logic             rise_s;
  logic             fall_s;
  logic             short_s;
  logic             dbl_s;
  logic             long_s;

  assign pressed_s = (btn_in == ACTIVE_LEVEL);
  assign rise_s    = pressed_s & ~p_q_r;
  assign fall_s    = ~pressed_s & p_q_r;

  // Next-state, timer and click-event decode.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    short_s = 1'b0;
    dbl_s   = 1'b0;
    long_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_s = PRESS1;
          timer_s = TMR_ONE;
        end else begin
          timer_s = TMR_ZERO;
        end
      end
      PRESS1: begin
        // A release on the terminal cycle wins over the long press.
        if (fall_s) begin
          state_s = GAP;
          timer_s = TMR_ONE;
        end else if (pressed_s && (timer_r == LONG_LAST)) begin
          long_s  = 1'b1;
          state_s = LONG;
          timer_s = TMR_ZERO;
        end else if (pressed_s) begin
          timer_s = timer_r + TMR_ONE;
        end else begin
          timer_s = timer_r;
        end
      end
      LONG: begin
        timer_s = TMR_ZERO;
        if (fall_s) begin
          state_s = IDLE;
        end else begin
          state_s = LONG;
        end
      end
      GAP: begin
        // A second press on the terminal cycle wins over the short click.
        if (rise_s) begin
          state_s = PRESS2;
          timer_s = TMR_ONE;
        end else if (timer_r == GAP_LAST) begin
          short_s = 1'b1;
          state_s = IDLE;
          timer_s = TMR_ZERO;
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end
      PRESS2: begin
        if (fall_s) begin
          dbl_s   = 1'b1;
          state_s = IDLE;
          timer_s = TMR_ZERO;
        end else if (pressed_s && (timer_r == LONG_LAST)) begin
          long_s  = 1'b1;
          state_s = LONG;
          timer_s = TMR_ZERO;
        end else if (pressed_s) begin
          timer_s = timer_r + TMR_ONE;
        end else begin
          timer_s = timer_r;
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = TMR_ZERO;
      end
    endcase
  end

  // State, timer, edge history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      timer_r       <= TMR_ZERO;
      p_q_r         <= 1'b0;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      p_q_r         <= pressed_s;
      held          <= pressed_s;
      press_pulse   <= rise_s;
      release_pulse <= fall_s;
      short_click   <= short_s;
      double_click  <= dbl_s;
      long_press    <= long_s;
      if (rise_s) begin
        press_count <= press_count + 8'd1;
      end else begin
        press_count <= press_count;
      end
    end
  end

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//
// Self-checking bench for button_event with LONG_TIME=20, DBL_GAP=10.
// A gesture-level reference model (run lengths of pressed/released samples,
// click count within a sequence) predicts every output after each clock.
// Inputs are driven and outputs checked on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_event;

  localparam logic ACT       = 1'b1;
  localparam int   LONG_TIME = 20;
  localparam int   DBL_GAP   = 10;
  localparam int   CNT_W     = 8;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       held;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_click;
  logic       double_click;
  logic       long_press;
  logic [7:0] press_count;

  int vectors;
  int miscompares;

  // Reference model state.
  bit         m_prev;
  int         run_p;
  int         run_r;
  int         seq_presses;
  bit         awaiting;
  bit         long_done;
  logic       exp_held, exp_press, exp_rel, exp_short, exp_dbl, exp_long;
  logic [7:0] exp_count;

  button_event #(
    .ACTIVE_LEVEL(ACT),
    .LONG_TIME   (LONG_TIME),
    .DBL_GAP     (DBL_GAP),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .held         (held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] excl;
    excl = ({short_click, double_click, long_press} inside {3'b000, 3'b001, 3'b010, 3'b100}) ? 8'd1 : 8'd0;
    check("held",          {7'd0, held},          {7'd0, exp_held});
    check("press_pulse",   {7'd0, press_pulse},   {7'd0, exp_press});
    check("release_pulse", {7'd0, release_pulse}, {7'd0, exp_rel});
    check("short_click",   {7'd0, short_click},   {7'd0, exp_short});
    check("double_click",  {7'd0, double_click},  {7'd0, exp_dbl});
    check("long_press",    {7'd0, long_press},    {7'd0, exp_long});
    check("press_count",   press_count,           exp_count);
    check("exclusive",     excl,                  8'd1);
  endtask

  task automatic model_clear();
    m_prev      = 1'b0;
    run_p       = 0;
    run_r       = 0;
    seq_presses = 0;
    awaiting    = 1'b0;
    long_done   = 1'b0;
    exp_held    = 1'b0;
    exp_press   = 1'b0;
    exp_rel     = 1'b0;
    exp_short   = 1'b0;
    exp_dbl     = 1'b0;
    exp_long    = 1'b0;
    exp_count   = 8'd0;
  endtask

  // Predicts outputs visible after the clock edge that samples pressed level p.
  task automatic model_sample(input bit p);
    bit rise;
    bit fall;
    rise      = p && !m_prev;
    fall      = !p && m_prev;
    exp_held  = p;
    exp_press = rise;
    exp_rel   = fall;
    exp_short = 1'b0;
    exp_dbl   = 1'b0;
    exp_long  = 1'b0;
    if (rise) exp_count = exp_count + 8'd1;
    if (p) begin
      run_p++;
      run_r = 0;
    end else begin
      run_r++;
      run_p = 0;
    end
    if (rise) begin
      if (awaiting) begin
        seq_presses = 2;
      end else begin
        seq_presses = 1;
        long_done   = 1'b0;
      end
      awaiting = 1'b0;
    end
    if (p && seq_presses > 0 && !long_done && run_p == LONG_TIME) begin
      exp_long  = 1'b1;
      long_done = 1'b1;
    end
    if (fall) begin
      if (long_done || seq_presses == 2) begin
        exp_dbl     = !long_done && (seq_presses == 2);
        seq_presses = 0;
        long_done   = 1'b0;
      end else begin
        awaiting = 1'b1;
      end
    end
    if (!p && awaiting && run_r == DBL_GAP) begin
      exp_short   = 1'b1;
      awaiting    = 1'b0;
      seq_presses = 0;
    end
    m_prev = p;
  endtask

  task automatic step(input bit p);
    @(negedge clk);
    check_all();
    btn_in = p ? ACT : ~ACT;
    model_sample(p);
  endtask

  task automatic hold_level(input bit p, input int n);
    repeat (n) step(p);
  endtask

  task automatic apply_reset(input bit p, input int n);
    @(negedge clk);
    rst_n  = 1'b0;
    btn_in = p ? ACT : ~ACT;
    model_clear();
    #1;
    check_all();
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    model_sample(p);
  endtask

  initial begin
    bit lvl;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    btn_in      = ~ACT;
    model_clear();

    // Button held through reset: rise on the first sample after release.
    apply_reset(1'b1, 3);
    hold_level(1'b1, 4);
    hold_level(1'b0, 15);

    // Single click.
    hold_level(1'b1, 5);
    hold_level(1'b0, 15);

    // Double click.
    hold_level(1'b1, 5);
    hold_level(1'b0, 4);
    hold_level(1'b1, 3);
    hold_level(1'b0, 15);

    // Long press.
    hold_level(1'b1, 30);
    hold_level(1'b0, 15);

    // Second press lands on the 10th released sample.
    hold_level(1'b1, 5);
    hold_level(1'b0, DBL_GAP - 1);
    hold_level(1'b1, 3);
    hold_level(1'b0, 15);

    // Release lands on the 20th sample.
    hold_level(1'b1, LONG_TIME - 1);
    hold_level(1'b0, 15);

    // Second press of a pair held long: long press, no double click.
    hold_level(1'b1, 4);
    hold_level(1'b0, 3);
    hold_level(1'b1, 25);
    hold_level(1'b0, 15);

    // Randomized run lengths.
    lvl = 1'b0;
    for (int i = 0; i < 60; i++) begin
      lvl = ~lvl;
      hold_level(lvl, int'($urandom_range(1, 26)));
    end
    hold_level(1'b0, 15);

    // Reset in the middle of the gap: pending short click is dropped.
    hold_level(1'b1, 3);
    hold_level(1'b0, 4);
    apply_reset(1'b0, 2);
    hold_level(1'b0, 15);

    // 256 clicks: press_count wraps back to 0.
    for (int i = 0; i < 256; i++) begin
      hold_level(1'b1, 2);
      hold_level(1'b0, 12);
    end
    step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
